// File: rtl/switch_port_pkg.sv
// Shared definitions for the KCPSM6 switch input port: register map and
// interrupt FSM encoding.
package switch_port_pkg;

    localparam logic [7:0] REG_STATE = 8'd0;
    localparam logic [7:0] REG_FLAGS = 8'd1;
    localparam logic [7:0] REG_MASK  = 8'd2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } irq_state_e;

    // Full 8-bit match; port_id wraps if base+offset overflows.
    function automatic logic [7:0] reg_addr(input logic [7:0] base, input logic [7:0] offset);
        return base + offset;
    endfunction

endpackage

// File: rtl/switch_input_port_if.sv
// KCPSM6 I/O bus as seen by an input peripheral: address, strobes, data and
// interrupt handshake.
interface switch_input_port_if;

    logic [7:0] port_id;
    logic       read_strobe;
    logic       write_strobe;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack;

    modport master (
        output port_id,
        output read_strobe,
        output write_strobe,
        output out_port,
        output interrupt_ack,
        input  in_port,
        input  interrupt
    );

    modport slave (
        input  port_id,
        input  read_strobe,
        input  write_strobe,
        input  out_port,
        input  interrupt_ack,
        output in_port,
        output interrupt
    );

endinterface

// File: rtl/switch_debounce.sv
// One switch bit: two-flop synchroniser followed by a tick-sampled debouncer
// that accepts a new level after DEBOUNCE_TICKS consecutive differing ticks.
module switch_debounce
    import switch_port_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_state,
    output logic o_change
);

    localparam int unsigned CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differs;
    logic             w_accept;

    assign w_differs = (r_sync != r_state);
    assign w_accept  = i_tick && w_differs && (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_state <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            if (i_tick) begin
                // Any agreeing tick throws away the partial count (glitch rejected).
                if (!w_differs) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_state <= r_sync;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_state  = r_state;
    assign o_change = w_accept;

endmodule

// File: rtl/switch_input_port.sv
// KCPSM6 input peripheral for the board switches: debounced state, W1C change
// flags, interrupt mask and a level interrupt with acknowledge handshake.
module switch_input_port
    import switch_port_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR      = 8'h00,
    parameter int unsigned TICK_DIV       = 1000,
    parameter int unsigned DEBOUNCE_TICKS = 10
) (
    input  logic                      CLK_IN,
    input  logic                      RESET_IN,
    input  logic [7:0]                SWITCHES,
    switch_input_port_if.slave        bus
);

    localparam int unsigned PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    localparam logic [7:0] ADDR_STATE = reg_addr(BASE_ADDR, REG_STATE);
    localparam logic [7:0] ADDR_FLAGS = reg_addr(BASE_ADDR, REG_FLAGS);
    localparam logic [7:0] ADDR_MASK  = reg_addr(BASE_ADDR, REG_MASK);

    logic [PRE_W-1:0] r_presc;
    logic             w_tick;
    logic [7:0]       w_sw_state;
    logic [7:0]       w_change;
    logic [7:0]       r_flags;
    logic [7:0]       r_mask;
    logic [7:0]       r_in_port;
    logic [7:0]       w_rd_data;
    logic [7:0]       w_flags_clr;
    logic             w_wr_flags;
    logic             w_wr_mask;
    logic             w_event;
    irq_state_e       r_fsm;
    irq_state_e       w_fsm_next;
    logic             w_interrupt;

    // Debounce sample prescaler
    assign w_tick = (r_presc == PRE_LAST);

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_bit
        switch_debounce #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
        ) u_debounce (
            .i_clk    (CLK_IN),
            .i_rst    (RESET_IN),
            .i_tick   (w_tick),
            .i_raw    (SWITCHES[g]),
            .o_state  (w_sw_state[g]),
            .o_change (w_change[g])
        );
    end

    assign w_wr_flags  = bus.write_strobe && (bus.port_id == ADDR_FLAGS);
    assign w_wr_mask   = bus.write_strobe && (bus.port_id == ADDR_MASK);
    assign w_flags_clr = w_wr_flags ? bus.out_port : 8'h00;

    // Only a fresh 0->1 flag on an enabled bit counts; stale flags never interrupt.
    assign w_event = |(w_change & ~r_flags & r_mask);

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            r_flags <= 8'h00;
            r_mask  <= 8'h00;
        end else begin
            r_flags <= (r_flags & ~w_flags_clr) | w_change;
            if (w_wr_mask) begin
                r_mask <= bus.out_port;
            end
        end
    end

    always_comb begin
        w_rd_data = 8'h00;
        if (bus.port_id == ADDR_STATE) begin
            w_rd_data = w_sw_state;
        end else if (bus.port_id == ADDR_FLAGS) begin
            w_rd_data = r_flags;
        end else if (bus.port_id == ADDR_MASK) begin
            w_rd_data = r_mask;
        end
    end

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            r_in_port <= 8'h00;
        end else begin
            r_in_port <= w_rd_data;
        end
    end

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next  = r_fsm;
        w_interrupt = 1'b0;
        unique case (r_fsm)
            ST_IDLE: begin
                if (w_event) begin
                    w_fsm_next = ST_PEND;
                end
            end
            ST_PEND: begin
                w_interrupt = 1'b1;
                // A new event arriving with the ack keeps the request alive.
                if (bus.interrupt_ack && !w_event) begin
                    w_fsm_next = ST_IDLE;
                end
            end
            default: begin
                w_fsm_next = ST_IDLE;
            end
        endcase
    end

    assign bus.in_port   = r_in_port;
    assign bus.interrupt = w_interrupt;

endmodule

// File: tb/tb_switch_input_port.sv
// Randomised scoreboard bench for switch_input_port against a cycle-level
// behavioural model of sampling, debouncing, flags and interrupt.
module tb_switch_input_port;

    localparam int unsigned TICK_DIV       = 4;
    localparam int unsigned DEBOUNCE_TICKS = 3;
    localparam logic [7:0]  BASE           = 8'h00;

    logic       CLK_IN   = 1'b0;
    logic       RESET_IN = 1'b1;
    logic [7:0] sw       = 8'hFF;

    switch_input_port_if bus ();

    switch_input_port #(
        .BASE_ADDR      (BASE),
        .TICK_DIV       (TICK_DIV),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) dut (
        .CLK_IN   (CLK_IN),
        .RESET_IN (RESET_IN),
        .SWITCHES (sw),
        .bus      (bus)
    );

    always #5 CLK_IN = ~CLK_IN;

    int vectors     = 0;
    int miscompares = 0;

    // Model: switch levels seen one and two edges ago, debounced levels, run of
    // consecutive disagreeing ticks per bit, and the edge count since reset.
    logic [7:0]  m_h1, m_h2, m_state, m_flags, m_mask;
    int          m_run [8];
    int unsigned m_k;
    bit          m_pend;
    logic [7:0]  exp_q [$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %02h, expected %02h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] a);
        if (a == BASE + 8'd0) return m_state;
        if (a == BASE + 8'd1) return m_flags;
        if (a == BASE + 8'd2) return m_mask;
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_h1 = 0; m_h2 = 0; m_state = 0; m_flags = 0; m_mask = 0;
        m_pend = 0; m_k = 0;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [7:0] chg, clr;
        bit         tick, evt;
        if (bus.read_strobe) exp_q.push_back(model_read(bus.port_id));
        chg  = 8'h00;
        tick = (m_k % TICK_DIV) == TICK_DIV - 1;
        if (tick) begin
            for (int i = 0; i < 8; i++) begin
                if (m_h2[i] != m_state[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEBOUNCE_TICKS) begin
                        chg[i]   = 1'b1;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        clr     = (bus.write_strobe && bus.port_id == BASE + 8'd1) ? bus.out_port : 8'h00;
        evt     = |(chg & ~m_flags & m_mask);
        m_state = m_state ^ chg;
        m_flags = (m_flags & ~clr) | chg;
        if (bus.write_strobe && bus.port_id == BASE + 8'd2) m_mask = bus.out_port;
        if (evt) m_pend = 1'b1;
        else if (bus.interrupt_ack) m_pend = 1'b0;
        m_h2 = m_h1;
        m_h1 = sw;
        m_k++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK_IN or posedge RESET_IN);
            if (RESET_IN) model_reset();
            else model_step();
        end
    end

    // Monitor: interrupt every cycle, read data whenever a read is outstanding.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge CLK_IN);
            if (!RESET_IN) begin
                chk("interrupt", {7'b0, bus.interrupt}, {7'b0, m_pend});
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("in_port", bus.in_port, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK_IN);
    endtask

    task automatic rd(input logic [7:0] a);
        @(negedge CLK_IN);
        bus.port_id     = a;
        bus.read_strobe = 1'b1;
        @(negedge CLK_IN);
        bus.read_strobe = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK_IN);
        bus.port_id      = a;
        bus.out_port     = d;
        bus.write_strobe = 1'b1;
        @(negedge CLK_IN);
        bus.write_strobe = 1'b0;
    endtask

    // Ack pulse, optionally together with a FLAGS W1C write in the same cycle.
    task automatic ack(input logic [7:0] clr);
        @(negedge CLK_IN);
        bus.interrupt_ack = 1'b1;
        if (clr != 8'h00) begin
            bus.port_id      = BASE + 8'd1;
            bus.out_port     = clr;
            bus.write_strobe = 1'b1;
        end
        @(negedge CLK_IN);
        bus.interrupt_ack = 1'b0;
        bus.write_strobe  = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge CLK_IN);
        RESET_IN = 1'b1;
        @(negedge CLK_IN);
        RESET_IN = 1'b0;
    endtask

    function automatic logic [7:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return BASE + 8'd0;
            1:       return BASE + 8'd1;
            2:       return BASE + 8'd2;
            3:       return BASE + 8'd3;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        bus.port_id       = 8'h00;
        bus.read_strobe   = 1'b0;
        bus.write_strobe  = 1'b0;
        bus.out_port      = 8'h00;
        bus.interrupt_ack = 1'b0;

        // Reset held with switches high, then watch STATE come up.
        cycles(3);
        chk("reset in_port", bus.in_port, 8'h00);
        chk("reset interrupt", {7'b0, bus.interrupt}, 8'h00);
        @(negedge CLK_IN);
        RESET_IN = 1'b0;
        for (int i = 0; i < 12; i++) rd(BASE);

        // Short glitch on bit 0 must be rejected.
        sw = 8'h00;
        reset_pulse();
        @(negedge CLK_IN);
        sw = 8'h01;
        cycles(6);
        sw = 8'h00;
        cycles(20);
        rd(BASE); rd(BASE + 8'd1);

        // Stable change with interrupts masked.
        sw = 8'h81;
        cycles(20);
        rd(BASE); rd(BASE + 8'd1); rd(BASE + 8'd2);

        // Enabled interrupt, ack, W1C.
        wr(BASE + 8'd2, 8'h01);
        sw = 8'h80;
        cycles(20);
        ack(8'h00);
        cycles(2);
        rd(BASE + 8'd1);
        wr(BASE + 8'd1, 8'h01);
        rd(BASE + 8'd1);

        // Sweep ack/W1C across the acceptance edge so one trial collides with it.
        for (int o = 0; o < 16; o++) begin
            wr(BASE + 8'd2, 8'h03);
            wr(BASE + 8'd1, 8'hFF);
            sw = sw ^ 8'h02;
            cycles(18);
            sw = sw ^ 8'h01;
            cycles(o);
            ack(8'h01);
            cycles(18);
            rd(BASE + 8'd1);
            ack(8'h00);
        end

        // Random traffic.
        for (int it = 0; it < 1500; it++) begin
            if ($urandom_range(0, 5) == 0) begin
                @(negedge CLK_IN);
                sw = sw ^ 8'($urandom);
            end
            case ($urandom_range(0, 9))
                0, 1, 2: rd(pick_addr());
                3:       wr(pick_addr(), 8'($urandom));
                4:       ack(8'h00);
                default: cycles($urandom_range(1, 4));
            endcase
        end

        // Reset while an interrupt is pending.
        wr(BASE + 8'd2, 8'hFF);
        wr(BASE + 8'd1, 8'hFF);
        cycles(2);
        sw = ~sw;
        cycles(20);
        chk("pending before reset", {7'b0, bus.interrupt}, 8'h01);
        @(negedge CLK_IN);
        #2;
        RESET_IN = 1'b1;
        #1;
        chk("async reset interrupt", {7'b0, bus.interrupt}, 8'h00);
        chk("async reset in_port", bus.in_port, 8'h00);
        @(negedge CLK_IN);
        RESET_IN = 1'b0;
        rd(BASE + 8'd2);
        rd(BASE + 8'd1);
        cycles(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
